// File: rtl/xike_pkg.sv
// Shared definitions for the spike waveform packer: default spike geometry,
// the packet header marker, derived packet length, FSM state types and a
// saturating counter helper.
package xike_pkg;

    localparam int          SPK_LENTH = 19;
    localparam logic [15:0] SYNC_WORD = 16'hA55A;
    localparam int          PKT_WORDS = 2 + 4 * SPK_LENTH;

    typedef enum logic {
        WR_IDLE,
        WR_COLLECT
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_HDR0,
        RD_HDR1,
        RD_DATA
    } rd_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spk_slot_ram.sv
// Beat storage for both packet slots: one write port, one registered read
// port (1-cycle latency). Contents are deliberately not reset.
module spk_slot_ram #(
    parameter int DEPTH = 38,
    parameter int AW    = 6,
    parameter int DW    = 128
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Synchronous write plus a registered read of the addressed beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/spk_wave_packer.sv
// Collects multi-beat spike waveforms into two ping-pong slots and streams
// each completed spike to the host as an AXI-Stream packet:
// HDR0 {sync, channel}, HDR1 time, then every sample of every beat.
module spk_wave_packer #(
    parameter int          SPK_LENTH = xike_pkg::SPK_LENTH,
    parameter logic [15:0] SYNC_WORD = xike_pkg::SYNC_WORD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         spk_stream_TVALID,
    input  logic [11:0]  spk_stream_CH,
    input  logic [31:0]  spk_stream_TIME,
    input  logic [15:0]  spk_stream_TDEST,
    input  logic [127:0] spk_stream_TDATA,
    output logic         out_TVALID,
    input  logic         out_TREADY,
    output logic [31:0]  out_TDATA,
    output logic         out_TLAST,
    output logic [15:0]  spk_cnt,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  err_cnt
);

    import xike_pkg::*;

    localparam int             DEPTH     = 2 * SPK_LENTH;
    localparam int             AW        = $clog2(DEPTH);
    localparam int             BW        = (SPK_LENTH > 1) ? $clog2(SPK_LENTH) : 1;
    localparam logic [15:0]    LAST_IDX  = 16'(SPK_LENTH - 1);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(SPK_LENTH - 1);

    function automatic logic [AW-1:0] slot_addr(input logic slot, input logic [AW-1:0] beat);
        return (slot ? AW'(SPK_LENTH) : AW'(0)) + beat;
    endfunction

    function automatic logic [31:0] lane_word(input logic [127:0] b, input logic [1:0] lane);
        logic [31:0] w;
        unique case (lane)
            2'd0: w = b[127:96];
            2'd1: w = b[95:64];
            2'd2: w = b[63:32];
            2'd3: w = b[31:0];
        endcase
        return w;
    endfunction

    // Writer state
    wr_state_e        wr_state_q, wr_state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [15:0]      exp_idx_q, exp_idx_d;
    logic             drop_act_q, drop_act_d;
    logic [15:0]      drop_idx_q, drop_idx_d;
    logic [1:0][11:0] ch_q, ch_d;
    logic [1:0][31:0] time_q, time_d;
    logic [15:0]      spk_cnt_q, spk_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             wr_done;

    // Slot occupancy shared between writer and reader
    logic [1:0]       slot_full_q, slot_full_d;

    // Reader state
    rd_state_e        rd_state_q, rd_state_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]    rd_beat_q, rd_beat_d;
    logic [BW-1:0]    cur_beat_q, cur_beat_d;
    logic [1:0]       lane_q, lane_d;
    logic [127:0]     beat_buf_q, beat_buf_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             rd_release;
    logic             xfer;
    logic [BW-1:0]    next_fetch;
    logic [AW-1:0]    rd_addr;
    logic [127:0]     rd_data;

    spk_slot_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (128)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (spk_stream_TDATA),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Writer: track beat indices, latch headers, decide store/drop/abort.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        exp_idx_d  = exp_idx_q;
        drop_act_d = drop_act_q;
        drop_idx_d = drop_idx_q;
        ch_d       = ch_q;
        time_d     = time_q;
        spk_cnt_d  = spk_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        wr_en      = 1'b0;
        wr_done    = 1'b0;
        wr_addr    = slot_addr(wr_ptr_q, AW'(spk_stream_TDEST));
        if (spk_stream_TVALID) begin
            unique case (wr_state_q)
                WR_IDLE: begin
                    if (spk_stream_TDEST == 16'd0) begin
                        if (!slot_full_q[wr_ptr_q]) begin
                            drop_act_d       = 1'b0;
                            ch_d[wr_ptr_q]   = spk_stream_CH;
                            time_d[wr_ptr_q] = spk_stream_TIME;
                            wr_en            = 1'b1;
                            exp_idx_d        = 16'd1;
                            wr_state_d       = WR_COLLECT;
                        end else begin
                            drop_cnt_d = sat_inc16(drop_cnt_q);
                            drop_act_d = 1'b1;
                            drop_idx_d = 16'd1;
                        end
                    end else if (drop_act_q && (spk_stream_TDEST == drop_idx_q)) begin
                        drop_idx_d = drop_idx_q + 16'd1;
                        if (drop_idx_q == LAST_IDX) begin
                            drop_act_d = 1'b0;
                        end
                    end else begin
                        err_cnt_d  = sat_inc16(err_cnt_q);
                        drop_act_d = 1'b0;
                    end
                end
                WR_COLLECT: begin
                    if (spk_stream_TDEST == exp_idx_q) begin
                        wr_en = 1'b1;
                        if (exp_idx_q == LAST_IDX) begin
                            wr_done    = 1'b1;
                            spk_cnt_d  = sat_inc16(spk_cnt_q);
                            wr_ptr_d   = ~wr_ptr_q;
                            wr_state_d = WR_IDLE;
                        end else begin
                            exp_idx_d = exp_idx_q + 16'd1;
                        end
                    end else if (spk_stream_TDEST == 16'd0) begin
                        err_cnt_d        = sat_inc16(err_cnt_q);
                        ch_d[wr_ptr_q]   = spk_stream_CH;
                        time_d[wr_ptr_q] = spk_stream_TIME;
                        wr_en            = 1'b1;
                        exp_idx_d        = 16'd1;
                    end else begin
                        err_cnt_d  = sat_inc16(err_cnt_q);
                        wr_state_d = WR_IDLE;
                    end
                end
                default: wr_state_d = WR_IDLE;
            endcase
        end
    end

    // Writer registers and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_ptr_q   <= 1'b0;
            exp_idx_q  <= '0;
            drop_act_q <= 1'b0;
            drop_idx_q <= '0;
            ch_q       <= '0;
            time_q     <= '0;
            spk_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
            exp_idx_q  <= exp_idx_d;
            drop_act_q <= drop_act_d;
            drop_idx_q <= drop_idx_d;
            ch_q       <= ch_d;
            time_q     <= time_d;
            spk_cnt_q  <= spk_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Slot occupancy: writer fills a free slot, reader frees the one it finished.
    always_comb begin
        slot_full_d = slot_full_q;
        if (rd_release) begin
            slot_full_d[rd_ptr_q] = 1'b0;
        end
        if (wr_done) begin
            slot_full_d[wr_ptr_q] = 1'b1;
        end
    end

    // Slot occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full_q <= '0;
        end else begin
            slot_full_q <= slot_full_d;
        end
    end

    assign xfer       = out_valid_q && out_TREADY;
    assign next_fetch = (rd_beat_q == LAST_BEAT) ? rd_beat_q : rd_beat_q + BW'(1);
    assign rd_addr    = slot_addr(rd_ptr_q, AW'(rd_beat_q));

    // Reader: walk headers then beats; the RAM prefetches the next beat while
    // the current one is emitted lane by lane from beat_buf.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_ptr_d    = rd_ptr_q;
        rd_beat_d   = rd_beat_q;
        cur_beat_d  = cur_beat_q;
        lane_d      = lane_q;
        beat_buf_d  = beat_buf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        rd_release  = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (slot_full_q[rd_ptr_q]) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {SYNC_WORD, 4'b0, ch_q[rd_ptr_q]};
                    out_last_d  = 1'b0;
                    rd_beat_d   = '0;
                    rd_state_d  = RD_HDR0;
                end
            end
            RD_HDR0: begin
                if (xfer) begin
                    out_data_d = time_q[rd_ptr_q];
                    rd_state_d = RD_HDR1;
                end
            end
            RD_HDR1: begin
                if (xfer) begin
                    beat_buf_d = rd_data;
                    out_data_d = rd_data[127:96];
                    cur_beat_d = '0;
                    lane_d     = 2'd0;
                    rd_beat_d  = next_fetch;
                    out_last_d = 1'b0;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (xfer) begin
                    if (out_last_q) begin
                        rd_release = 1'b1;
                        rd_ptr_d   = ~rd_ptr_q;
                        out_last_d = 1'b0;
                        if (slot_full_q[~rd_ptr_q]) begin
                            out_data_d = {SYNC_WORD, 4'b0, ch_q[~rd_ptr_q]};
                            rd_beat_d  = '0;
                            rd_state_d = RD_HDR0;
                        end else begin
                            out_valid_d = 1'b0;
                            rd_state_d  = RD_IDLE;
                        end
                    end else if (lane_q == 2'd3) begin
                        beat_buf_d = rd_data;
                        out_data_d = rd_data[127:96];
                        cur_beat_d = cur_beat_q + BW'(1);
                        lane_d     = 2'd0;
                        rd_beat_d  = next_fetch;
                        out_last_d = 1'b0;
                    end else begin
                        lane_d     = lane_q + 2'd1;
                        out_data_d = lane_word(beat_buf_q, lane_q + 2'd1);
                        out_last_d = (cur_beat_q == LAST_BEAT) && (lane_q == 2'd2);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Reader registers and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= RD_IDLE;
            rd_ptr_q    <= 1'b0;
            rd_beat_q   <= '0;
            cur_beat_q  <= '0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_beat_q   <= rd_beat_d;
            cur_beat_q  <= cur_beat_d;
            lane_q      <= lane_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Copy of the beat being emitted; sample data, so it is not reset.
    always_ff @(posedge clk) begin
        beat_buf_q <= beat_buf_d;
    end

    assign out_TVALID = out_valid_q;
    assign out_TDATA  = out_data_q;
    assign out_TLAST  = out_last_q;
    assign spk_cnt    = spk_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_spk_wave_packer.sv
// Scoreboard bench for spk_wave_packer: stimulus pushes expected words,
// an independent monitor pops and compares each accepted output word.
module tb_spk_wave_packer;

    localparam int L = 19;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         spk_stream_TVALID;
    logic [11:0]  spk_stream_CH;
    logic [31:0]  spk_stream_TIME;
    logic [15:0]  spk_stream_TDEST;
    logic [127:0] spk_stream_TDATA;
    logic         out_TVALID;
    logic         out_TREADY;
    logic [31:0]  out_TDATA;
    logic         out_TLAST;
    logic [15:0]  spk_cnt;
    logic [15:0]  drop_cnt;
    logic [15:0]  err_cnt;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   words_seen   = 0;
    int   ready_mode   = 1;

    spk_wave_packer #(
        .SPK_LENTH (L),
        .SYNC_WORD (16'hA55A)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .spk_stream_TVALID (spk_stream_TVALID),
        .spk_stream_CH     (spk_stream_CH),
        .spk_stream_TIME   (spk_stream_TIME),
        .spk_stream_TDEST  (spk_stream_TDEST),
        .spk_stream_TDATA  (spk_stream_TDATA),
        .out_TVALID        (out_TVALID),
        .out_TREADY        (out_TREADY),
        .out_TDATA         (out_TDATA),
        .out_TLAST         (out_TLAST),
        .spk_cnt           (spk_cnt),
        .drop_cnt          (drop_cnt),
        .err_cnt           (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] beatData(input int seed, input int k);
        return {32'(seed + k), 32'(seed + k + 1), 32'(seed + k + 2), 32'(seed + k + 3)};
    endfunction

    task automatic pushPacket(input logic [11:0] ch, input logic [31:0] tm, input int seed);
        exp_t e;
        e.data = {16'hA55A, 4'h0, ch};
        e.last = 1'b0;
        exp_q.push_back(e);
        e.data = tm;
        exp_q.push_back(e);
        for (int k = 0; k < L; k++) begin
            for (int l = 0; l < 4; l++) begin
                e.data = 32'(seed + k + l);
                e.last = (k == L - 1) && (l == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic driveBeat(input int tdest, input logic [11:0] ch, input logic [31:0] tm, input int seed);
        @(posedge clk);
        #1;
        spk_stream_TVALID = 1'b1;
        spk_stream_TDEST  = 16'(tdest);
        spk_stream_CH     = ch;
        spk_stream_TIME   = tm;
        spk_stream_TDATA  = beatData(seed, tdest);
    endtask

    task automatic endBeats();
        @(posedge clk);
        #1;
        spk_stream_TVALID = 1'b0;
    endtask

    task automatic applyStimulus(input logic [11:0] ch, input logic [31:0] tm, input int seed, input bit expect_pkt);
        if (expect_pkt) pushPacket(ch, tm, seed);
        for (int k = 0; k < L; k++) driveBeat(k, ch, tm, seed);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
        repeat (10) @(posedge clk);
    endtask

    task automatic waitWords(input int target);
        int n = 0;
        while (words_seen < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("reach_word40", 32'(words_seen >= target), 32'd1);
    endtask

    task automatic checkCounters(input string tag, input int s, input int d, input int e);
        checkOutput({tag, "_spk_cnt"}, 32'(spk_cnt), 32'(s));
        checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(d));
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'(e));
    endtask

    // Ready generator: held low, held high, or 50% random stalls.
    initial begin : ready_driver
        out_TREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_TREADY = 1'b0;
                1:       out_TREADY = 1'b1;
                default: out_TREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares accepted words to the queue head, checks stalled words
    // against the head too, and checks the next header follows TLAST directly.
    initial begin : monitor
        exp_t e;
        bit   prev_last;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_last = 1'b0;
            end else begin
                if (prev_last && exp_q.size() > 0) begin
                    checkOutput("b2b_hdr_valid", 32'(out_TVALID), 32'd1);
                end
                prev_last = 1'b0;
                if (out_TVALID && out_TREADY) begin
                    if (exp_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_word: actual=%h required=no word", out_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("word_data", out_TDATA, e.data);
                        checkOutput("word_last", 32'(out_TLAST), 32'(e.last));
                        prev_last = e.last;
                        words_seen++;
                    end
                end else if (out_TVALID && exp_q.size() > 0) begin
                    e = exp_q[0];
                    checkOutput("stall_data", out_TDATA, e.data);
                    checkOutput("stall_last", 32'(out_TLAST), 32'(e.last));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int target;
        rst_n             = 1'b0;
        spk_stream_TVALID = 1'b0;
        spk_stream_CH     = '0;
        spk_stream_TIME   = '0;
        spk_stream_TDEST  = '0;
        spk_stream_TDATA  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tvalid", 32'(out_TVALID), 32'd0);
        checkOutput("rst_tlast", 32'(out_TLAST), 32'd0);
        checkOutput("rst_tdata", out_TDATA, 32'd0);
        checkCounters("rst", 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] single spike, ready high");
        ready_mode = 1;
        applyStimulus(12'd5, 32'd1000, 0, 1'b1);
        endBeats();
        checkOutput("latency_edge_e", 32'(out_TVALID), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_edge_e1", 32'(out_TVALID), 32'd1);
        waitDrain("drain_single");
        checkCounters("single", 1, 0, 0);

        $display("[TB] single spike, random stalls");
        ready_mode = 2;
        applyStimulus(12'd5, 32'd1000, 0, 1'b1);
        endBeats();
        waitDrain("drain_stall");
        checkCounters("stall", 2, 0, 0);

        $display("[TB] three spikes with ready low");
        ready_mode = 0;
        repeat (3) @(posedge clk);
        applyStimulus(12'd1, 32'd111, 100, 1'b1);
        applyStimulus(12'd2, 32'd222, 200, 1'b1);
        applyStimulus(12'd3, 32'd333, 300, 1'b0);
        endBeats();
        repeat (3) @(posedge clk);
        #1;
        checkCounters("three", 4, 1, 0);
        checkOutput("held_tvalid", 32'(out_TVALID), 32'd1);
        checkOutput("held_hdr0", out_TDATA, 32'hA55A0001);
        ready_mode = 1;
        waitDrain("drain_three");

        $display("[TB] restart on TDEST 0 mid-spike");
        for (int k = 0; k < 8; k++) driveBeat(k, 12'd7, 32'd77, 400);
        applyStimulus(12'd9, 32'd99, 500, 1'b1);
        endBeats();
        checkCounters("restart", 5, 1, 1);
        waitDrain("drain_restart");

        $display("[TB] index gap and lone beat");
        driveBeat(0, 12'd4, 32'd44, 800);
        driveBeat(1, 12'd4, 32'd44, 800);
        driveBeat(3, 12'd4, 32'd44, 800);
        endBeats();
        checkCounters("gap", 5, 1, 2);
        driveBeat(4, 12'd4, 32'd44, 800);
        endBeats();
        checkCounters("lone", 5, 1, 3);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("gap_no_output", 32'(out_TVALID), 32'd0);

        $display("[TB] reset during word 40");
        applyStimulus(12'd3, 32'd33, 600, 1'b1);
        endBeats();
        target = words_seen + 39;
        waitWords(target);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tvalid", 32'(out_TVALID), 32'd0);
        checkOutput("midrst_tlast", 32'(out_TLAST), 32'd0);
        checkOutput("midrst_tdata", out_TDATA, 32'd0);
        checkCounters("midrst", 0, 0, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("postrst_idle", 32'(out_TVALID), 32'd0);
        applyStimulus(12'hABC, 32'hDEADBEEF, 700, 1'b1);
        endBeats();
        waitDrain("drain_postrst");
        checkCounters("postrst", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
